key_event_arb: RTL and testbench
================================

KEY_EVENT_ARB -- requirements
Module: key_event_arb

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, event queue depth; power of two, 2..16.
REQ-002 Parameter LONG_CYC, default 50_000_000, long-press hold time in clk cycles; minimum 2.
REQ-003 Parameter CNT_W, default 26, width of each long-press counter; must satisfy 2^CNT_W > LONG_CYC.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 key_flag  input  4  per-key one-cycle "debounced transition" strobe, one bit per key from its filter.
REQ-007 key_state  input  4  per-key debounced level; 0 = pressed, 1 = released; sampled only when the matching key_flag bit is 1.
REQ-008 evt_valid  output  1  head event available.
REQ-009 evt_ready  input  1  consumer accepts head event when evt_valid=1.
REQ-010 evt_key  output  2  key index of the head event.
REQ-011 evt_press  output  1  head event is a press.
REQ-012 evt_long  output  1  head event is a long press; evt_press=0 and evt_long=0 together mean release.
REQ-013 ovf  output  1  sticky flag: an un-queued event was overwritten.
REQ-014 ovf_clr  input  1  clears ovf.

Function
REQ-015 Each key has one pending slot holding {valid, type}, where type is press, release or long.
- A key_flag bit sets that key's slot with type = press if key_state=0, release if key_state=1, visible on the next cycle.
REQ-016 Arbitration is round-robin among valid slots.
- At most one grant per cycle.
- Search starts at the index after the last granted key; after reset the last-granted pointer is 3, so key 0 has first priority.
REQ-017 A grant is allowed when the FIFO is not full, or when it is full and a pop (evt_valid & evt_ready) occurs in the same cycle.
- A grant writes {key, type} to the FIFO tail and clears the granted slot.
REQ-018 Latency: key_flag in cycle t with an empty FIFO and no competing slots gives evt_valid=1 in cycle t+2.
REQ-019 The FIFO is a first-word-fall-through queue.
- evt_key, evt_press and evt_long reflect the head entry whenever evt_valid=1.
- These outputs are 0 when the FIFO is empty.
- The head holds stable while evt_valid=1 and evt_ready=0.
REQ-020 A new event arriving at a slot that is already valid and not granted that cycle overwrites the slot with the newest type and sets ovf.
REQ-021 A new event arriving at a slot in the same cycle that slot is granted leaves the slot valid with the new type and does not set ovf.
REQ-022 ovf_clr takes priority over a simultaneous ovf set; ovf reads 0 the next cycle.
REQ-023 A full FIFO with no pop holds all slots unchanged; events are never silently discarded except as described in REQ-020.
REQ-024 Multiple key_flag bits in one cycle set all affected slots; they drain one per cycle in round-robin order.

Reset
REQ-025 While rst=1:
- all slots are invalid;
- the FIFO is empty;
- the round-robin pointer is 3;
- all long-press counters are 0;
- evt_valid=0, evt_key=0, evt_press=0, evt_long=0, ovf=0.
REQ-026 Assertion of rst mid-operation discards all queued and pending events immediately.
- The first event after deassertion requires a fresh key_flag.

Configuration
REQ-027 Macro KEY_LONG_PRESS_EN, when defined, adds one CNT_W counter per key.
- Each counter clears and starts on a press event for its key, and clears on a release event.
- When the count reaches LONG_CYC-1, the key's slot is set with type long, under the REQ-020/021 rules; the counter then stops and does not fire again until the next press.
REQ-028 Without KEY_LONG_PRESS_EN:
- no counters are built;
- evt_long is constant 0;
- the long type is never generated.

Verification
REQ-029 Reset, then key_flag=0001 with key_state=1110 for one cycle.
- Two cycles later: evt_valid=1, evt_key=0, evt_press=1, evt_long=0.
REQ-030 key_flag=1111 in one cycle with evt_ready=1.
- Events drain on consecutive cycles with evt_key order 0,1,2,3.
- A following flag on key 0 alone is granted next, with the pointer continuing after key 3.
REQ-031 evt_ready=0; issue 5 single-key events on distinct cycles with FIFO_DEPTH=4.
- The FIFO fills at 4 entries; the 5th event stays pending; ovf stays 0.
- One pop then admits the 5th event in the same cycle.
REQ-032 With the FIFO full, issue a press then a release on key 2 before any pop.
- ovf=1; the slot holds release.
- ovf_clr=1 for one cycle returns ovf to 0.
REQ-033 With KEY_LONG_PRESS_EN and LONG_CYC=10, press key 1 and hold.
- A press event, then exactly one long event (evt_long=1, evt_press=0) 10 cycles after the press flag.
- A release within 9 cycles produces no long event.
REQ-034 Assert rst while 3 events are queued.
- evt_valid drops to 0 asynchronously; after deassertion there are no events until a new key_flag.

Source files
------------

// File: rtl/key_event_arb.sv
// Four-key event arbiter: per-key pending slots, round-robin grant into a FWFT event FIFO.
// Optional long-press detection is built when KEY_LONG_PRESS_EN is defined.
module key_event_arb #(
  parameter int FIFO_DEPTH = 4,
  parameter int LONG_CYC   = 50_000_000,
  parameter int CNT_W      = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_flag,
  input  logic [3:0] key_state,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_key,
  output logic       evt_press,
  output logic       evt_long,
  output logic       ovf,
  input  logic       ovf_clr
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [1:0] TYP_REL = 2'd0;
  localparam logic [1:0] TYP_PRS = 2'd1;
  localparam logic [1:0] TYP_LNG = 2'd2;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || LONG_CYC < 2 ||
      (64'(1) << CNT_W) <= 64'(LONG_CYC)) begin : g_bad_cfg
    $error("key_event_arb: illegal parameter set");
  end

  logic [3:0]       slot_vld_q, slot_vld_d;
  logic [3:0][1:0]  slot_typ_q, slot_typ_d;
  logic [1:0]       ptr_q, ptr_d;
  logic             ovf_q, ovf_set;
  logic [3:0]       ev_set;
  logic [3:0][1:0]  ev_typ;
  logic [3:0]       long_fire;
  logic             gnt_found, gnt;
  logic [1:0]       gnt_idx, cand;
  logic [3:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             fifo_full, pop;
  logic [3:0]       head;

  assign fifo_full = (cnt_q == FULL_CNT);
  assign evt_valid = (cnt_q != '0);
  assign pop       = evt_valid & evt_ready;
  assign head      = mem_q[rd_q];
  assign evt_key   = evt_valid ? head[3:2] : 2'd0;
  assign evt_press = evt_valid && (head[1:0] == TYP_PRS);
  assign ovf       = ovf_q;

  // A fresh debounced edge always wins over a long-press firing in the same cycle.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      ev_set[k] = key_flag[k] | long_fire[k];
      ev_typ[k] = key_flag[k] ? (key_state[k] ? TYP_REL : TYP_PRS) : TYP_LNG;
    end
  end

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = ptr_q;
    cand      = ptr_q;
    for (int i = 1; i <= 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!gnt_found && slot_vld_q[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    gnt   = gnt_found && (!fifo_full || pop);
    ptr_d = gnt ? gnt_idx : ptr_q;
  end

  // A slot being granted this cycle can absorb a new event without loss.
  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_typ_d = slot_typ_q;
    ovf_set    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (gnt && gnt_idx == 2'(k)) slot_vld_d[k] = 1'b0;
      if (ev_set[k]) begin
        slot_vld_d[k] = 1'b1;
        slot_typ_d[k] = ev_typ[k];
        if (slot_vld_q[k] && !(gnt && gnt_idx == 2'(k))) ovf_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_vld_q <= '0;
      slot_typ_q <= '0;
      ptr_q      <= 2'd3;
      ovf_q      <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      slot_vld_q <= slot_vld_d;
      slot_typ_q <= slot_typ_d;
      ptr_q      <= ptr_d;
      if (ovf_clr)      ovf_q <= 1'b0;
      else if (ovf_set) ovf_q <= 1'b1;
      if (gnt) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(gnt) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (gnt) mem_q[wr_q] <= {gnt_idx, slot_typ_q[gnt_idx]};
  end

`ifdef KEY_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);

  logic [3:0][CNT_W-1:0] lp_cnt_q;
  logic [3:0]            lp_run_q;

  assign evt_long = evt_valid && (head[1:0] == TYP_LNG);

  always_comb begin
    for (int k = 0; k < 4; k++)
      long_fire[k] = lp_run_q[k] && (lp_cnt_q[k] == LONG_LAST) && !key_flag[k];
  end

  // Counter parks at its terminal value once fired; only a new press re-arms it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lp_cnt_q <= '0;
      lp_run_q <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (key_flag[k]) begin
          lp_cnt_q[k] <= '0;
          lp_run_q[k] <= ~key_state[k];
        end else if (lp_run_q[k]) begin
          if (lp_cnt_q[k] == LONG_LAST) lp_run_q[k] <= 1'b0;
          else                          lp_cnt_q[k] <= lp_cnt_q[k] + 1'b1;
        end
      end
    end
  end
`else
  assign evt_long  = 1'b0;
  assign long_fire = 4'b0000;
`endif

endmodule

// File: tb/tb_key_event_arb.sv
// Directed bench for key_event_arb; long-press expectations follow KEY_LONG_PRESS_EN.
module tb_key_event_arb;

  logic       clk, rst;
  logic [3:0] key_flag, key_state;
  logic       evt_valid, evt_ready;
  logic [1:0] evt_key;
  logic       evt_press, evt_long, ovf, ovf_clr;
  int         n_vec, n_err, n_long;

  key_event_arb #(.FIFO_DEPTH(4), .LONG_CYC(10), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .key_flag(key_flag), .key_state(key_state),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key),
    .evt_press(evt_press), .evt_long(evt_long), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic v, input logic [1:0] k,
                            input logic p, input logic l);
    check_val({tag, ".valid"}, 32'(evt_valid), 32'(v));
    check_val({tag, ".key"},   32'(evt_key),   32'(k));
    check_val({tag, ".press"}, 32'(evt_press), 32'(p));
    check_val({tag, ".long"},  32'(evt_long),  32'(l));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    key_flag = 4'b0000; key_state = 4'b1111; evt_ready = 1'b0; ovf_clr = 1'b0;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; key_flag = 4'b0000; key_state = 4'b1111; evt_ready = 1'b0; ovf_clr = 1'b0;
    #12;
    check_head("rst_out", 1'b0, 2'd0, 1'b0, 1'b0);
    check_val("rst_ovf", 32'(ovf), 32'd0);
    tick;
    rst = 1'b0;

    // First press on key 0: visible two edges after the flag
    key_flag = 4'b0001; key_state = 4'b1110;
    tick;
    key_flag = 4'b0000; key_state = 4'b1111;
    check_val("lat_t1_valid", 32'(evt_valid), 32'd0);
    tick;
    check_head("lat_t2", 1'b1, 2'd0, 1'b1, 1'b0);
    evt_ready = 1'b1;
    tick;
    evt_ready = 1'b0;
    check_val("lat_pop_valid", 32'(evt_valid), 32'd0);

    // All four keys at once drain 0,1,2,3; then 0 wins over 3 after pointer passed 3
    do_reset;
    evt_ready = 1'b1;
    key_flag = 4'b1111; key_state = 4'b0000;
    tick;
    key_flag = 4'b0000; key_state = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick;
      check_head($sformatf("rr_drain%0d", i), 1'b1, 2'(i), 1'b1, 1'b0);
    end
    key_flag = 4'b1001; key_state = 4'b0110;
    tick;
    key_flag = 4'b0000; key_state = 4'b1111;
    check_val("rr_gap_valid", 32'(evt_valid), 32'd0);
    tick;
    check_head("rr_wrap0", 1'b1, 2'd0, 1'b1, 1'b0);
    tick;
    check_head("rr_wrap3", 1'b1, 2'd3, 1'b1, 1'b0);
    tick;
    check_val("rr_empty", 32'(evt_valid), 32'd0);

    // New event on a slot in its grant cycle keeps the new type without ovf
    do_reset;
    evt_ready = 1'b1;
    key_flag = 4'b0010; key_state = 4'b0000;
    tick;
    key_flag = 4'b0010; key_state = 4'b1111;
    tick;
    key_flag = 4'b0000;
    check_head("same_gnt_a", 1'b1, 2'd1, 1'b1, 1'b0);
    check_val("same_gnt_ovf_a", 32'(ovf), 32'd0);
    tick;
    check_head("same_gnt_b", 1'b1, 2'd1, 1'b0, 1'b0);
    check_val("same_gnt_ovf_b", 32'(ovf), 32'd0);
    tick;
    check_val("same_gnt_empty", 32'(evt_valid), 32'd0);

    // Five events into a depth-4 FIFO: fifth waits, then enters alongside a pop
    do_reset;
    for (int i = 0; i < 5; i++) begin
      key_flag  = (i == 4) ? 4'b0001 : 4'(1 << i);
      key_state = (i == 4) ? 4'b1111 : 4'b0000;
      tick;
    end
    key_flag = 4'b0000; key_state = 4'b1111;
    tick;
    check_head("full_hold", 1'b1, 2'd0, 1'b1, 1'b0);
    check_val("full_ovf", 32'(ovf), 32'd0);
    evt_ready = 1'b1;
    tick;
    evt_ready = 1'b0;
    check_head("full_pop1", 1'b1, 2'd1, 1'b1, 1'b0);
    evt_ready = 1'b1;
    tick; check_head("full_pop2", 1'b1, 2'd2, 1'b1, 1'b0);
    tick; check_head("full_pop3", 1'b1, 2'd3, 1'b1, 1'b0);
    tick; check_head("full_fifth", 1'b1, 2'd0, 1'b0, 1'b0);
    tick; check_val("full_empty", 32'(evt_valid), 32'd0);
    check_val("full_ovf_end", 32'(ovf), 32'd0);

    // Overwrite while full sets ovf; clear wins against a simultaneous set
    do_reset;
    key_flag = 4'b1111; key_state = 4'b0000;
    tick;
    key_flag = 4'b0000;
    tick; tick; tick; tick;
    key_flag = 4'b0110; key_state = 4'b0000;
    tick;
    check_val("ovf_fresh", 32'(ovf), 32'd0);
    key_flag = 4'b0100; key_state = 4'b1111;
    tick;
    check_val("ovf_set", 32'(ovf), 32'd1);
    check_head("ovf_head_hold", 1'b1, 2'd0, 1'b1, 1'b0);
    key_flag = 4'b0010; key_state = 4'b0000; ovf_clr = 1'b1;
    tick;
    key_flag = 4'b0000; key_state = 4'b1111; ovf_clr = 1'b0;
    check_val("ovf_clr_prio", 32'(ovf), 32'd0);
    evt_ready = 1'b1;
    tick; check_head("ovf_d1", 1'b1, 2'd1, 1'b1, 1'b0);
    check_val("ovf_stays0", 32'(ovf), 32'd0);
    tick; check_head("ovf_d2", 1'b1, 2'd2, 1'b1, 1'b0);
    tick; check_head("ovf_d3", 1'b1, 2'd3, 1'b1, 1'b0);
    tick; check_head("ovf_slot1", 1'b1, 2'd1, 1'b1, 1'b0);
    tick; check_head("ovf_slot2_rel", 1'b1, 2'd2, 1'b0, 1'b0);
    tick; check_val("ovf_empty", 32'(evt_valid), 32'd0);

    // Press and hold key 1: press event, then one long event when the count hits 9
    do_reset;
    evt_ready = 1'b1;
    key_flag = 4'b0010; key_state = 4'b1101;
    tick;
    key_flag = 4'b0000;
    tick;
    check_head("hold_press", 1'b1, 2'd1, 1'b1, 1'b0);
    n_long = 0;
    for (int e = 3; e <= 25; e++) begin
      tick;
`ifdef KEY_LONG_PRESS_EN
      if (e == 12) check_head("hold_long", 1'b1, 2'd1, 1'b0, 1'b1);
      else if (e == 11) check_val("hold_pre_long", 32'(evt_valid), 32'd0);
`endif
      if (evt_valid && evt_long) n_long++;
    end
`ifdef KEY_LONG_PRESS_EN
    check_val("hold_long_count", 32'(n_long), 32'd1);
`else
    check_val("hold_long_count", 32'(n_long), 32'd0);
`endif

    // Release before the terminal count: no long event at all
    do_reset;
    evt_ready = 1'b1;
    key_flag = 4'b0010; key_state = 4'b1101;
    tick;
    n_long = 0;
    for (int e = 2; e <= 30; e++) begin
      key_flag  = (e == 9) ? 4'b0010 : 4'b0000;
      key_state = 4'b1111;
      tick;
      if (evt_valid && evt_long) n_long++;
    end
    check_val("early_rel_long", 32'(n_long), 32'd0);

    // Asynchronous reset with three queued events
    do_reset;
    key_flag = 4'b0111; key_state = 4'b0000;
    tick;
    key_flag = 4'b0000; key_state = 4'b1111;
    tick; tick; tick;
    check_head("q3_before", 1'b1, 2'd0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 check_head("async_rst", 1'b0, 2'd0, 1'b0, 1'b0);
    tick;
    rst = 1'b0;
    evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick;
    check_val("post_rst_valid", 32'(evt_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
